// File: rtl/alu_status_pipe_if.sv
// Handshake/operand bundle for alu_status_pipe.
// master = operand source + result consumer side, slave = the ALU itself.
interface alu_status_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             clr_c;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             sign;

  modport master (
    output a, b, op, clr_c, in_valid, out_ready,
    input  in_ready, out_valid, out, zero, carry, overflow, sign
  );

  modport slave (
    input  a, b, op, clr_c, in_valid, out_ready,
    output in_ready, out_valid, out, zero, carry, overflow, sign
  );
endinterface

// File: rtl/alu_status_pipe.sv
// Registered ALU with zero/carry/overflow/sign flags, latency 1,
// valid/ready on both sides and a stored carry used by ADC.
// Build option: define ALU_SAT_EN to turn ops 6/7 into signed
// saturating add/sub (SADD/SSUB) instead of SHL/SHR.
module alu_status_pipe #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  alu_status_pipe_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ADC = 3'd5;
  localparam logic [2:0] OP_6   = 3'd6;
  localparam logic [2:0] OP_7   = 3'd7;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sign_q, sign_d;
  logic             valid_q, valid_d;
  logic             c_q, c_d;

  logic             accept;
  logic             cin;
  logic             a_msb, b_msb;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v;

`ifdef ALU_SAT_EN
  // Clamp to the signed extreme on overflow; the direction follows the sign of a.
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] r,
                                                 input logic ovf,
                                                 input logic a_neg);
    if (!ovf) return r;
    return a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  // A single output register: a new op may enter whenever the slot is empty or draining.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Combinational ALU: result, carry and overflow for the op presented this cycle.
  always_comb begin
    a_msb   = bus.a[WIDTH-1];
    b_msb   = bus.b[WIDTH-1];
    cin     = (bus.op == OP_ADC) && !bus.clr_c && c_q;
    add_ext = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    sub_ext = {1'b0, bus.a} - {1'b0, bus.b};
    add_v   = (a_msb == b_msb) && (add_ext[WIDTH-1] != a_msb);
    sub_v   = (a_msb != b_msb) && (sub_ext[WIDTH-1] != a_msb);
    res     = add_ext[WIDTH-1:0];
    res_c   = add_ext[WIDTH];
    res_v   = add_v;
    case (bus.op)
      OP_ADD, OP_ADC: ;
      OP_SUB: begin
        res   = sub_ext[WIDTH-1:0];
        res_c = sub_ext[WIDTH];
        res_v = sub_v;
      end
      OP_AND: begin res = bus.a & bus.b; res_c = 1'b0; res_v = 1'b0; end
      OP_OR:  begin res = bus.a | bus.b; res_c = 1'b0; res_v = 1'b0; end
      OP_XOR: begin res = bus.a ^ bus.b; res_c = 1'b0; res_v = 1'b0; end
`ifdef ALU_SAT_EN
      OP_6: begin
        res   = sat_clamp(add_ext[WIDTH-1:0], add_v, a_msb);
        res_c = add_ext[WIDTH];
        res_v = add_v;
      end
      OP_7: begin
        res   = sat_clamp(sub_ext[WIDTH-1:0], sub_v, a_msb);
        res_c = sub_ext[WIDTH];
        res_v = sub_v;
      end
`else
      OP_6: begin
        res   = {bus.a[WIDTH-2:0], 1'b0};
        res_c = a_msb;
        res_v = 1'b0;
      end
      OP_7: begin
        res   = {1'b0, bus.a[WIDTH-1:1]};
        res_c = bus.a[0];
        res_v = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  // Next state: load on accept, drop valid when drained, otherwise hold everything.
  always_comb begin
    out_d   = out_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    valid_d = valid_q;
    c_d     = c_q;
    if (accept) begin
      out_d   = res;
      zero_d  = (res == '0);
      carry_d = res_c;
      ovf_d   = res_v;
      sign_d  = res[WIDTH-1];
      valid_d = 1'b1;
      c_d     = res_c;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register and stored carry; reset discards any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      valid_q <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      valid_q <= valid_d;
      c_q     <= c_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.sign      = sign_q;

endmodule
